maxnet_job_driver: RTL and testbench

//  Initiator side of the Maxnet start/finish handshake. Assembles jobs (epsilon, a1..a4) from a
//  32-bit valid/ready word stream and drives the Maxnet start/operand inputs, holding operands stable.

---
 rtl/maxnet_pkg.sv | 20 ++
 rtl/maxnet_job_driver_if.sv | 39 +++
 rtl/maxnet_watchdog.sv | 36 +++
 rtl/maxnet_job_driver.sv | 149 ++++++++++++++
 tb/tb_maxnet_job_driver.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet job driver: FSM states and operand slot indices.
package maxnet_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } state_e;

  localparam int NUM_WORDS = 5;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] IDX_EPS = 3'd0;
  localparam logic [IDX_W-1:0] IDX_A1  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_A2  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_A3  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_A4  = 3'd4;

endpackage

// File: rtl/maxnet_job_driver_if.sv
// Job word stream, Maxnet start/finish/operand signals and result port of the job driver.
interface maxnet_job_driver_if #(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              mx_start;
  logic [DATA_W-1:0] mx_epsilon;
  logic [DATA_W-1:0] mx_a1;
  logic [DATA_W-1:0] mx_a2;
  logic [DATA_W-1:0] mx_a3;
  logic [DATA_W-1:0] mx_a4;
  logic              mx_finish;
  logic [DATA_W-1:0] mx_out;
  logic              mx_overflow;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_overflow;
  logic              res_timeout;

  // master is the job driver; slave is the host plus the Maxnet core around it
  modport master (
    input  in_valid, in_data, mx_finish, mx_out, mx_overflow, res_ready,
    output in_ready, mx_start, mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4,
           res_valid, res_data, res_overflow, res_timeout
  );

  modport slave (
    output in_valid, in_data, mx_finish, mx_out, mx_overflow, res_ready,
    input  in_ready, mx_start, mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4,
           res_valid, res_data, res_overflow, res_timeout
  );

endinterface

// File: rtl/maxnet_watchdog.sv
// Saturating cycle counter that flags expiry once it has counted TIMEOUT_CYC-1 enabled cycles.
module maxnet_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              W    = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/maxnet_job_driver.sv
// Initiator side of the Maxnet start/finish handshake: collects five job words, pulses start,
// waits for a fresh finish (or watchdog expiry) and offers the result on a valid/ready port.
module maxnet_job_driver
  import maxnet_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  maxnet_job_driver_if.master bus,
  output logic                busy,
  output logic [CNT_W-1:0]    job_count
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] ops_q [NUM_WORDS];
  logic [DATA_W-1:0] ops_d [NUM_WORDS];
  logic              armed_q, armed_d;
  logic              in_ready_q, in_ready_d;
  logic              mx_start_q, mx_start_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_ovf_q, res_ovf_d;
  logic              res_to_q, res_to_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  job_count_q, job_count_d;
  logic              wd_clear, wd_en, wd_expired;

  maxnet_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ops_d       = ops_q;
    armed_d     = armed_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_to_d    = res_to_q;
    job_count_d = job_count_q;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          ops_d[idx_q] = bus.in_data;
          if (idx_q == IDX_A4) begin
            idx_d   = IDX_EPS;
            state_d = ST_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_START: begin
        wd_clear = 1'b1;
        armed_d  = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // A finish only counts after it has been seen low, so a level left over
        // from the previous job cannot complete this one; finish beats expiry.
        if (armed_q && bus.mx_finish) begin
          res_data_d = bus.mx_out;
          res_ovf_d  = bus.mx_overflow;
          res_to_d   = 1'b0;
          state_d    = ST_RESULT;
        end else if (wd_expired) begin
          res_data_d = '0;
          res_ovf_d  = 1'b0;
          res_to_d   = 1'b1;
          state_d    = ST_RESULT;
        end else if (!bus.mx_finish) begin
          armed_d = 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_valid_q && bus.res_ready) begin
          job_count_d = job_count_q + 1'b1;
          idx_d       = IDX_EPS;
          state_d     = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    mx_start_d  = (state_d == ST_START);
    res_valid_d = (state_d == ST_RESULT);
    busy_d      = !((state_d == ST_LOAD) && (idx_d == IDX_EPS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      idx_q       <= IDX_EPS;
      ops_q       <= '{default: '0};
      armed_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      mx_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_to_q    <= 1'b0;
      busy_q      <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ops_q       <= ops_d;
      armed_q     <= armed_d;
      in_ready_q  <= in_ready_d;
      mx_start_q  <= mx_start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_to_q    <= res_to_d;
      busy_q      <= busy_d;
      job_count_q <= job_count_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.mx_start     = mx_start_q;
  assign bus.mx_epsilon   = ops_q[IDX_EPS];
  assign bus.mx_a1        = ops_q[IDX_A1];
  assign bus.mx_a2        = ops_q[IDX_A2];
  assign bus.mx_a3        = ops_q[IDX_A3];
  assign bus.mx_a4        = ops_q[IDX_A4];
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_overflow = res_ovf_q;
  assign bus.res_timeout  = res_to_q;
  assign busy             = busy_q;
  assign job_count        = job_count_q;

endmodule

// File: tb/tb_maxnet_job_driver.sv
// Self-checking bench for maxnet_job_driver: Maxnet stub with programmable finish latency,
// randomized job words and handshakes, per-job expectations derived from the stub settings.
`timescale 1ns/1ps
module tb_maxnet_job_driver;

  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 16;
  localparam int NWORDS      = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  maxnet_job_driver_if #(.DATA_W(DATA_W)) bus ();

  maxnet_job_driver #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  logic [DATA_W-1:0] job_w [NWORDS];
  bit                toggle_valid;
  int                ready_delay;

  bit                stub_stale;
  bit                stub_never;
  int                stub_stale_cyc;
  int                stub_rise;
  logic [DATA_W-1:0] stub_out;
  logic              stub_ovf;
  bit                stub_run;
  int                stub_cnt;

  task automatic checkOutput(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Maxnet stub: finish drops on start (unless holding a stale level), rises stub_rise cycles later
  always @(negedge clk) begin
    if (rst) begin
      bus.mx_finish   = 1'b0;
      bus.mx_out      = '0;
      bus.mx_overflow = 1'b0;
      stub_run        = 1'b0;
      stub_cnt        = 0;
    end else if (bus.mx_start) begin
      stub_cnt = 0;
      stub_run = 1'b1;
      if (!stub_stale) bus.mx_finish = 1'b0;
    end else if (stub_run) begin
      stub_cnt++;
      if (stub_stale && stub_cnt == stub_stale_cyc) bus.mx_finish = 1'b0;
      if (!stub_never && stub_cnt == stub_rise) begin
        bus.mx_finish   = 1'b1;
        bus.mx_out      = stub_out;
        bus.mx_overflow = stub_ovf;
        stub_run        = 1'b0;
      end
    end
  end

  task automatic setStub(input int rise, input bit never, input bit stale, input int stale_cyc,
                         input logic [DATA_W-1:0] out, input logic ovf);
    stub_rise      = rise;
    stub_never     = never;
    stub_stale     = stale;
    stub_stale_cyc = stale_cyc;
    stub_out       = out;
    stub_ovf       = ovf;
  endtask

  task automatic randomWords();
    for (int i = 0; i < NWORDS; i++) job_w[i] = $urandom;
  endtask

  task automatic applyStimulus();
    int                acc, guard, lat, start_cnt, exp_lat;
    bit                phase, v, seen, ready_bad, hold_ok, exp_to;
    logic [DATA_W-1:0] exp_data;
    logic              exp_ovf;

    // A fresh finish is taken at WAIT cycle rise-1; the watchdog allows WAIT cycles 0..TIMEOUT_CYC-1
    exp_to   = stub_never || (stub_rise > TIMEOUT_CYC);
    exp_data = exp_to ? '0 : stub_out;
    exp_ovf  = exp_to ? 1'b0 : stub_ovf;
    exp_lat  = exp_to ? TIMEOUT_CYC + 1 : stub_rise + 1;

    acc = 0; guard = 0; phase = 1'b0;
    while (acc < NWORDS && guard < 200) begin
      @(negedge clk);
      if (toggle_valid) begin
        phase = !phase;
        v     = phase;
      end else begin
        v = ($urandom_range(0, 3) != 0);
      end
      bus.in_valid = v;
      bus.in_data  = v ? job_w[acc] : $urandom;
      if (v && bus.in_ready) acc++;
      guard++;
    end
    checkOutput("words_accepted", acc, NWORDS);

    seen = 1'b0; guard = 0;
    while (!seen && guard < 20) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.mx_start) seen = 1'b1;
      guard++;
    end
    checkOutput("start_seen", seen, 1);
    checkOutput("operands_at_start",
                {bus.mx_epsilon, bus.mx_a1, bus.mx_a2, bus.mx_a3, bus.mx_a4},
                {job_w[0], job_w[1], job_w[2], job_w[3], job_w[4]});
    checkOutput("busy_in_job", busy, 1);

    start_cnt = 1; lat = 0; ready_bad = 1'b0;
    while (!bus.res_valid && lat < TIMEOUT_CYC + 40) begin
      @(negedge clk);
      lat++;
      bus.in_valid = $urandom_range(0, 1);
      bus.in_data  = $urandom;
      if (bus.mx_start) start_cnt++;
      if (bus.in_ready) ready_bad = 1'b1;
    end
    checkOutput("start_pulses", start_cnt, 1);
    checkOutput("result_latency", lat, exp_lat);
    checkOutput("in_ready_low_busy", ready_bad, 0);
    checkOutput("operands_held",
                {bus.mx_epsilon, bus.mx_a1, bus.mx_a2, bus.mx_a3, bus.mx_a4},
                {job_w[0], job_w[1], job_w[2], job_w[3], job_w[4]});
    checkOutput("res_data", bus.res_data, exp_data);
    checkOutput("res_overflow", bus.res_overflow, exp_ovf);
    checkOutput("res_timeout", bus.res_timeout, exp_to);
    checkOutput("count_before_ack", job_count, model_count);

    hold_ok = 1'b1;
    for (int c = 0; c < ready_delay; c++) begin
      @(negedge clk);
      bus.in_valid = $urandom_range(0, 1);
      bus.in_data  = $urandom;
      if (!(bus.res_valid && bus.res_data == exp_data && bus.res_overflow == exp_ovf &&
            bus.res_timeout == exp_to && !bus.in_ready)) hold_ok = 1'b0;
    end
    if (ready_delay > 0) checkOutput("res_hold", hold_ok, 1);

    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    model_count   = (model_count + 1) % (1 << CNT_W);
    checkOutput("res_valid_drop", bus.res_valid, 0);
    checkOutput("job_count", job_count, model_count);
    checkOutput("idle_after", {busy, bus.in_ready}, 2'b01);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
                {busy, bus.in_ready, bus.mx_start, bus.res_valid, bus.res_timeout},
                5'b0);
    checkOutput("reset_count", job_count, 0);
    checkOutput("reset_operands", {bus.mx_epsilon, bus.mx_a4, bus.res_data}, 0);
    model_count = 0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("load_after_reset", {busy, bus.in_ready}, 2'b01);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    toggle_valid  = 1'b0;
    ready_delay   = 0;
    setStub(3, 1'b0, 1'b0, 0, '0, 1'b0);
    repeat (3) @(negedge clk);
    pulseReset();

    // Job 1: fixed words, finish three cycles after start with out=8
    job_w = '{32'd1, 32'd5, 32'd3, 32'd8, 32'd2};
    setStub(3, 1'b0, 1'b0, 0, 32'h8, 1'b0);
    ready_delay = 2;
    applyStimulus();
    checkOutput("t1_count", job_count, 1);

    // Job 2: finish still high from job 1 until it drops, fresh finish at 10 cycles
    randomWords();
    setStub(10, 1'b0, 1'b1, 4, $urandom | 32'h100, 1'b0);
    applyStimulus();

    // Job 3: stub never finishes
    randomWords();
    setStub(5, 1'b1, 1'b0, 0, $urandom, 1'b1);
    applyStimulus();

    // Job 4: overflow result held for 20 cycles of res_ready low
    randomWords();
    setStub($urandom_range(2, 8), 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 1'b1);
    ready_delay = 20;
    applyStimulus();

    // Finish on the very cycle the watchdog expires, then one cycle too late
    ready_delay = 1;
    randomWords();
    setStub(TIMEOUT_CYC, 1'b0, 1'b0, 0, $urandom, 1'b1);
    applyStimulus();
    randomWords();
    setStub(TIMEOUT_CYC + 1, 1'b0, 1'b0, 0, $urandom, 1'b1);
    applyStimulus();

    for (int j = 0; j < 6; j++) begin
      int rise;
      rise = $urandom_range(2, 12);
      randomWords();
      setStub(rise, 1'b0, $urandom_range(0, 1), $urandom_range(1, rise - 1),
              $urandom, $urandom_range(0, 1));
      ready_delay = $urandom_range(0, 4);
      applyStimulus();
    end

    // Reset after three words of a job, then a complete job
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("busy_partial", busy, 1);
    pulseReset();
    job_w = '{32'd7, 32'd1, 32'd2, 32'd3, 32'd4};
    setStub(4, 1'b0, 1'b0, 0, $urandom, 1'b0);
    ready_delay = 3;
    applyStimulus();
    checkOutput("t5_count", job_count, 1);

    // Three back-to-back jobs with in_valid toggling every other cycle
    pulseReset();
    toggle_valid = 1'b1;
    ready_delay  = 0;
    for (int j = 0; j < 3; j++) begin
      randomWords();
      setStub($urandom_range(2, 9), 1'b0, 1'b0, 0, $urandom, $urandom_range(0, 1));
      applyStimulus();
    end
    checkOutput("t6_count", job_count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got no finish, expected end of run");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
